// File: rtl/debounce_fsm.sv
// Switch debouncer: 2-flop synchronizer feeding a four-state
// tick-counted FSM with a debounced level and edge pulses.
module debounce_fsm #(
    parameter int M = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [3:0] LAST = 4'(M - 1);

    logic       r_sync1;
    logic       r_sync2;
    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_level;

    logic w_sw_s;
    logic w_done;

    // sw is asynchronous; only the second flop is safe to use
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sw_s = r_sync2;
    assign w_done = tick && (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ZERO;
            r_cnt   <= 4'd0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                ZERO: begin
                    if (w_sw_s) begin
                        r_state <= WAIT1;
                        r_cnt   <= 4'd0;
                    end
                end
                // a mismatch outranks a tick on the same cycle
                WAIT1: begin
                    if (!w_sw_s) begin
                        r_state <= ZERO;
                    end else if (w_done) begin
                        r_state <= ONE;
                        r_level <= 1'b1;
                    end else if (tick) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ONE: begin
                    if (!w_sw_s) begin
                        r_state <= WAIT0;
                        r_cnt   <= 4'd0;
                    end
                end
                WAIT0: begin
                    if (w_sw_s) begin
                        r_state <= ONE;
                    end else if (w_done) begin
                        r_state <= ZERO;
                        r_level <= 1'b0;
                    end else if (tick) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ZERO;
                    r_cnt   <= 4'd0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign db_level = r_level;
    assign db_rise  = (r_state == WAIT1) && w_sw_s && w_done;
    assign db_fall  = (r_state == WAIT0) && !w_sw_s && w_done;

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm: M=3 with sparse ticks and
// M=1 with tick tied high, sharing clock, reset and sw.
module tb_debounce_fsm;

    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic sw;
    logic tick1;
    logic db_level, db_rise, db_fall;
    logic lv1, rise1, fall1;

    int errs   = 0;
    int checks = 0;
    int cyc_n;
    int n_rise, n_fall, rise_at, fall_at;
    int n_rise1, n_fall1, rise1_at, fall1_at;
    int both;
    logic lvl1_h [0:63];

    always #5 clk = ~clk;

    debounce_fsm #(.M(3)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .sw       (sw),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall)
    );

    debounce_fsm #(.M(1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick1),
        .sw       (sw),
        .db_level (lv1),
        .db_rise  (rise1),
        .db_fall  (fall1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        cyc_n    = 0;
        n_rise   = 0;
        n_fall   = 0;
        rise_at  = -1;
        fall_at  = -1;
        n_rise1  = 0;
        n_fall1  = 0;
        rise1_at = -1;
        fall1_at = -1;
    endtask

    // one cycle: drive at posedge+1, sample at negedge
    task automatic cyc(input logic t, input logic s);
        tick = t;
        sw   = s;
        @(negedge clk);
        if (db_rise) begin n_rise++; rise_at = cyc_n; end
        if (db_fall) begin n_fall++; fall_at = cyc_n; end
        if (rise1) begin n_rise1++; rise1_at = cyc_n; end
        if (fall1) begin n_fall1++; fall1_at = cyc_n; end
        if ((db_rise && db_fall) || (rise1 && fall1)) both++;
        if (cyc_n < 64) lvl1_h[cyc_n] = lv1;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic do_reset(input logic s);
        reset = 1'b1;
        sw    = s;
        tick  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        clr();
    endtask

    initial begin
        reset = 1'b1;
        sw    = 1'b0;
        tick  = 1'b0;
        tick1 = 1'b1;
        both  = 0;
        clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_level", db_level, 0);
        chk("rst_rise", db_rise, 0);
        chk("rst_fall", db_fall, 0);
        chk("rst_level1", lv1, 0);
        chk("rst_rise1", rise1, 0);
        chk("rst_fall1", fall1, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clr();

        // clean press, tick every 4th cycle
        for (int n = 0; n < 20; n++) cyc(n % 4 == 3, 1'b1);
        chk("press_rises", n_rise, 1);
        chk("press_rise_at", rise_at, 11);
        chk("press_falls", n_fall, 0);
        chk("press_level", db_level, 1);

        // clean release
        clr();
        for (int n = 0; n < 20; n++) cyc(n % 4 == 3, 1'b0);
        chk("rel_falls", n_fall, 1);
        chk("rel_fall_at", fall_at, 11);
        chk("rel_rises", n_rise, 0);
        chk("rel_level", db_level, 0);

        // 1-cycle glitch; mismatch meets tick in WAIT1
        clr();
        for (int n = 0; n < 16; n++) cyc(n % 4 == 3, n == 0);
        chk("glitch_rises", n_rise, 0);
        chk("glitch_level", db_level, 0);
        chk("glitch_rises1", n_rise1, 0);
        chk("glitch_level1", lv1, 0);

        // WAIT1 with cnt=2, then tick together with sw_s=0
        clr();
        for (int n = 0; n < 12; n++) cyc(n >= 3 && n <= 5, n < 3);
        chk("abort_rises", n_rise, 0);
        chk("abort_level", db_level, 0);

        // bounce every 2 cycles, then hold high
        clr();
        for (int n = 0; n < 40; n++)
            cyc(n % 4 == 3, (n >= 20) || ((n / 2) % 2 == 0));
        chk("bounce_rises", n_rise, 1);
        chk("bounce_rise_at", rise_at, 31);
        chk("bounce_falls", n_fall, 0);
        chk("bounce_level", db_level, 1);

        // release, then reset mid-WAIT0 (cnt=1)
        clr();
        for (int n = 0; n < 5; n++) cyc(n == 3, 1'b0);
        chk("w0_level", db_level, 1);
        reset = 1'b1;
        #1;
        chk("w0_rst_level", db_level, 0);
        chk("w0_rst_fall", db_fall, 0);
        chk("w0_rst_cnt", u_dut.r_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 0; n < 16; n++) cyc(n % 4 == 3, 1'b0);
        chk("w0_falls", n_fall, 0);
        chk("w0_level_end", db_level, 0);

        // reset held with sw=1, then released
        do_reset(1'b1);
        for (int n = 0; n < 20; n++) cyc(n % 4 == 3, 1'b1);
        chk("rel1_rises", n_rise, 1);
        chk("rel1_rise_at", rise_at, 11);
        chk("rel1_level", db_level, 1);

        // M=1, tick always high
        do_reset(1'b0);
        for (int n = 0; n < 14; n++) cyc(1'b0, n < 6);
        chk("m1_rise_at", rise1_at, 3);
        chk("m1_fall_at", fall1_at, 9);
        chk("m1_rises", n_rise1, 1);
        chk("m1_falls", n_fall1, 1);
        chk("m1_lvl_c3", lvl1_h[3], 0);
        chk("m1_lvl_c4", lvl1_h[4], 1);
        chk("m1_lvl_c9", lvl1_h[9], 1);
        chk("m1_lvl_c10", lvl1_h[10], 0);

        chk("rise_fall_excl", both, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
